uart_message_printer: RTL and testbench
=======================================

// Module: uart_message_printer
// PURPOSE
//  Sits between the UART receiver and transmitter. Collects ASCII '0'/'1' characters into bytes, MSB first.
//  Stores each completed byte in an internal 16-entry message store.
//  After each byte, transmits the whole stored message, followed by CR LF.
//  Exposes debug taps: state, store address, last bit and bit counter.
// PARAMETERS
//  MSG_DEPTH  16  entries in the message store; must equal 2**ADDR_W
//  ADDR_W     4   width of the addr port and the internal pointers
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  rst          in   1       asynchronous, active-low reset
//  tx_data      out  8       byte offered to the UART transmitter
//  new_tx_data  out  1       one-cycle strobe: tx_data valid, send it
//  tx_busy      in   1       transmitter busy; no strobe issued while high
//  new_rx_data  in   1       one-cycle strobe: rx_data holds a new character
//  rx_data      in   8       received ASCII character
//  state        out  1       0 = COLLECT, 1 = PRINT
//  addr         out  ADDR_W  store write pointer (slot of the next/just-written byte)
//  bytes        out  1       value of the most recently accepted bit
//  counter      out  4       bits accepted into the current byte, 0..7
// BEHAVIOUR
//  Reset (rst low, async):
//   - outputs: tx_data=0, new_tx_data=0, state=0, addr=0, bytes=0, counter=0
//   - internal: shift register=0, read pointer=0
//   - store contents are not reset.
//  Inputs sampled on rising clk while rst high. Strobes arriving during reset are lost.
//  COLLECT state:
//   - new_rx_data with rx_data=8'h30 ('0') or 8'h31 ('1'):
//     - shift = {shift[6:0], bit}; bytes = bit; counter += 1.
//   - Any other character is ignored: shift, counter and bytes are unchanged.
//   - 8th accepted bit (counter was 7), all in the same edge:
//     - write {shift[6:0], bit} to store[addr]
//     - counter -> 0; read pointer -> 0; state -> PRINT.
//  PRINT state:
//   - new_rx_data is ignored; characters are dropped, not queued.
//   - Send sequence: store[0], ..., store[addr], then 8'h0D, then 8'h0A.
//   - Each item: when tx_busy is low and no strobe was issued the previous cycle:
//     - drive tx_data and pulse new_tx_data high for exactly 1 cycle.
//     - Minimum spacing between strobes is 2 cycles.
//   - tx_busy high: hold; tx_data keeps its last value; no strobe.
//   - After the LF strobe, in the same edge: addr += 1 (wraps 15 -> 0); state -> COLLECT.
//  Wrap: after 16 bytes addr returns to 0. The next print sends only store[0] (the newest byte) plus CR LF.
//  new_tx_data is never high in COLLECT. tx_data holds its last value between strobes.
//  Reset mid-byte or mid-print: immediate abort; returns to the reset values above.
// TESTING
//  1 Reset, tx_busy=0, send "01000001" (one strobe per ~5 cycles):
//    - store[0]=8'h41; strobes 41,0D,0A; addr=1, state=0.
//  2 Then send "01000010":
//    - strobes 41,42,0D,0A; addr=2; counter steps 0..7 and then 0 during collection.
//  3 Interleave 'x' (8'h78) between bits:
//    - counter and bytes unchanged for 'x'; result identical to scenario 1.
//  4 Hold tx_busy=1 during PRINT for 20 cycles:
//    - no new_tx_data while high; sequence resumes intact after release.
//  5 Send bits during PRINT:
//    - all ignored; counter stays 0 until state returns to 0.
//  6 Assert rst mid-print, then release:
//    - all outputs back to reset values; a new 8-bit entry prints from store[0].

Source files
------------

// File: rtl/uart_message_printer.sv
// Collects ASCII '0'/'1' characters into MSB-first bytes, keeps them in a small
// message store, and after every completed byte replays the whole message plus CR LF.
module uart_message_printer #(
   parameter int MSG_DEPTH = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [7:0]        tx_data,
   output logic              new_tx_data,
   input  logic              tx_busy,
   input  logic              new_rx_data,
   input  logic [7:0]        rx_data,
   output logic              state,
   output logic [ADDR_W-1:0] addr,
   output logic              bytes,
   output logic [3:0]        counter
);

   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] PRINT   = 1'b1;

   localparam logic [1:0] PH_DATA = 2'd0;
   localparam logic [1:0] PH_CR   = 2'd1;
   localparam logic [1:0] PH_LF   = 2'd2;

   logic [7:0]        shift_q;
   logic [ADDR_W-1:0] rd_ptr;
   logic [1:0]        phase;
   logic [7:0]        mem [MSG_DEPTH];

   logic       is_bit;
   logic       accept;
   logic       rx_bit;
   logic [7:0] next_shift;
   logic       byte_done;
   logic       send;

   assign is_bit     = (rx_data == 8'h30) || (rx_data == 8'h31);
   assign accept     = (state == COLLECT) && new_rx_data && is_bit;
   assign rx_bit     = rx_data[0];
   assign next_shift = {shift_q[6:0], rx_bit};
   assign byte_done  = accept && (counter == 4'd7);

   // Transmit handshake: new_tx_data is a one-cycle strobe qualifying tx_data; it is
   // only raised when tx_busy was low at the edge and no strobe was issued the cycle
   // before, so consecutive strobes are always at least two cycles apart.
   assign send = (state == PRINT) && !tx_busy && !new_tx_data;

   // Message store is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (byte_done) begin
         mem[addr] <= next_shift;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_data     <= 8'h00;
         new_tx_data <= 1'b0;
         state       <= COLLECT;
         addr        <= '0;
         bytes       <= 1'b0;
         counter     <= 4'd0;
         shift_q     <= 8'h00;
         rd_ptr      <= '0;
         phase       <= PH_DATA;
      end else begin
         new_tx_data <= 1'b0;
         case (state)
            COLLECT: begin
               if (accept) begin
                  shift_q <= next_shift;
                  bytes   <= rx_bit;
                  if (counter == 4'd7) begin
                     counter <= 4'd0;
                     rd_ptr  <= '0;
                     phase   <= PH_DATA;
                     state   <= PRINT;
                  end else begin
                     counter <= counter + 4'd1;
                  end
               end
            end
            PRINT: begin
               if (send) begin
                  new_tx_data <= 1'b1;
                  case (phase)
                     PH_DATA: begin
                        tx_data <= mem[rd_ptr];
                        if (rd_ptr == addr) begin
                           phase <= PH_CR;
                        end else begin
                           rd_ptr <= rd_ptr + 1'b1;
                        end
                     end
                     PH_CR: begin
                        tx_data <= 8'h0D;
                        phase   <= PH_LF;
                     end
                     default: begin
                        // Final LF: the just-printed slot becomes history, pointer advances.
                        tx_data <= 8'h0A;
                        phase   <= PH_DATA;
                        addr    <= addr + 1'b1;
                        state   <= COLLECT;
                     end
                  endcase
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_message_printer.sv
// Randomized bench for uart_message_printer: a character-level message model predicts
// every transmitted byte, and debug taps are compared after each received character.
module tb_uart_message_printer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       new_tx_data;
   logic       tx_busy;
   logic       new_rx_data;
   logic [7:0] rx_data;
   logic       state;
   logic [3:0] addr;
   logic       bytes;
   logic [3:0] counter;

   int checks = 0;
   int errors = 0;

   // Reference model: message slots, bit accumulation and the expected transmit stream.
   logic [7:0] exp_q[$];
   logic [7:0] m_msg [16];
   int         m_addr;
   int         m_cnt;
   int         m_val;
   logic       m_last;

   // Transmit monitor history.
   logic prev_strobe;
   logic prev_state;
   int   strobes;

   uart_message_printer #(.MSG_DEPTH(16), .ADDR_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy),
      .new_rx_data (new_rx_data),
      .rx_data     (rx_data),
      .state       (state),
      .addr        (addr),
      .bytes       (bytes),
      .counter     (counter)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock: advance to the falling edge and inspect the transmit side.
   task automatic tick();
      @(negedge clk);
      if (rst) begin
         if (new_tx_data) begin
            strobes++;
            check("strobe_spacing", {31'd0, prev_strobe}, 32'd0);
            check("strobe_while_busy", {31'd0, tx_busy}, 32'd0);
            check("strobe_from_print", {31'd0, prev_state}, 32'd1);
            if (exp_q.size() == 0) begin
               check("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            end else begin
               check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
         end
         prev_strobe = new_tx_data;
         prev_state  = state;
      end else begin
         prev_strobe = 1'b0;
         prev_state  = 1'b0;
      end
   endtask

   function automatic logic [7:0] junk_char();
      logic [7:0] c;
      do c = 8'($urandom_range(0, 255)); while (c == 8'h30 || c == 8'h31);
      return c;
   endfunction

   task automatic model_char(input logic [7:0] c);
      if (exp_q.size() != 0 || (c != 8'h30 && c != 8'h31)) return;
      m_last = c[0];
      m_val  = (m_val * 2 + int'(c[0])) % 256;
      m_cnt  = m_cnt + 1;
      if (m_cnt == 8) begin
         m_msg[m_addr] = 8'(m_val);
         for (int k = 0; k <= m_addr; k++) exp_q.push_back(m_msg[k]);
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         m_addr = (m_addr + 1) % 16;
         m_cnt  = 0;
         m_val  = 0;
      end
   endtask

   task automatic send_char(input logic [7:0] c);
      tick();
      #1;
      new_rx_data = 1'b1;
      rx_data     = c;
      model_char(c);
      tick();
      new_rx_data = 1'b0;
      check("counter", {28'd0, counter}, m_cnt);
      check("bytes", {31'd0, bytes}, {31'd0, m_last});
      check("state", {31'd0, state}, {31'd0, exp_q.size() != 0});
   endtask

   // mode 0: clean bits, 1: 'x' before every bit, 2: random junk sprinkled in.
   task automatic send_byte(input logic [7:0] b, input int mode, input int gap);
      for (int i = 7; i >= 0; i--) begin
         if (mode == 1) send_char(8'h78);
         if (mode == 2 && $urandom_range(0, 2) == 0) send_char(junk_char());
         send_char(b[i] ? 8'h31 : 8'h30);
         repeat (gap) tick();
      end
   endtask

   task automatic wait_idle(input bit rand_busy);
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         #1;
         tx_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
         n++;
      end
      tx_busy = 1'b0;
      check("print_done", exp_q.size(), 32'd0);
      exp_q.delete();
      tick();
      check("idle_state", {31'd0, state}, 32'd0);
      check("idle_addr", {28'd0, addr}, m_addr);
      check("idle_strobe", {31'd0, new_tx_data}, 32'd0);
   endtask

   task automatic do_reset();
      tick();
      #1;
      rst         = 1'b0;
      new_rx_data = 1'b0;
      tx_busy     = 1'b0;
      #1;
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_strobe", {31'd0, new_tx_data}, 32'd0);
      check("rst_state", {31'd0, state}, 32'd0);
      check("rst_addr", {28'd0, addr}, 32'd0);
      check("rst_bytes", {31'd0, bytes}, 32'd0);
      check("rst_counter", {28'd0, counter}, 32'd0);
      tick();
      tick();
      #1;
      rst = 1'b1;
      exp_q.delete();
      m_addr = 0;
      m_cnt  = 0;
      m_val  = 0;
      m_last = 1'b0;
   endtask

   initial begin
      int snap;
      rst         = 1'b0;
      tx_busy     = 1'b0;
      new_rx_data = 1'b0;
      rx_data     = 8'h00;
      prev_strobe = 1'b0;
      prev_state  = 1'b0;
      strobes     = 0;
      for (int k = 0; k < 16; k++) m_msg[k] = 8'h00;
      do_reset();

      // "01000001" then "01000010": message grows to 41 42.
      send_byte(8'h41, 0, 3);
      wait_idle(1'b0);
      send_byte(8'h42, 0, 3);
      wait_idle(1'b0);

      // Same 'A' with 'x' between bits after a fresh reset.
      do_reset();
      send_byte(8'h41, 1, 1);
      wait_idle(1'b0);

      // Busy hold during print, with bits arriving that must be dropped.
      send_byte(8'hA5, 0, 0);
      tick();
      tick();
      #1;
      tx_busy = 1'b1;
      snap = strobes;
      for (int i = 0; i < 5; i++) send_char(8'h30 + 8'($urandom_range(0, 1)));
      repeat (10) tick();
      check("busy_hold", strobes - snap, 32'd0);
      #1;
      tx_busy = 1'b0;
      wait_idle(1'b0);

      // Reset in the middle of a print, then a single new entry.
      send_byte(8'($urandom_range(0, 255)), 0, 0);
      repeat (4) tick();
      do_reset();
      send_byte(8'($urandom_range(0, 255)), 2, 1);
      wait_idle(1'b0);

      // Random traffic, enough bytes to wrap the store.
      for (int n = 0; n < 20; n++) begin
         send_byte(8'($urandom_range(0, 255)), 2, $urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0) begin
            for (int j = 0; j < 4; j++) send_char(8'h30 + 8'($urandom_range(0, 1)));
         end
         wait_idle(1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
